// File: rtl/pe_job_scheduler.sv
// Planter/harvester for the PE vector: plants length-prefixed dot-product jobs on free PEs
// round-robin and drains finished PE output buffers round-robin into one result stream.
module pe_job_scheduler #(
    parameter int unsigned PE_COUNT = 8,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned PE_W     = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_job_valid,
    output logic                     o_job_ready,
    input  logic [LEN_W-1:0]         i_job_length,
    input  logic                     i_elem_valid,
    output logic                     o_elem_ready,
    input  logic [31:0]              i_elem_left,
    input  logic [31:0]              i_elem_right,
    output logic [PE_COUNT-1:0]      o_pe_active,
    output logic [LEN_W-1:0]         o_pe_length,
    output logic [31:0]              o_pe_left,
    output logic [31:0]              o_pe_right,
    output logic [PE_COUNT-1:0]      o_pe_read,
    input  logic [PE_COUNT-1:0]      i_pe_out_empty,
    input  logic [PE_COUNT*32-1:0]   i_pe_out,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [31:0]              o_res_data,
    output logic [PE_W-1:0]          o_res_pe,
    output logic [PE_COUNT-1:0]      o_busy_mask
);

    typedef enum logic {PIdle, PStream} plant_state_e;
    typedef enum logic [1:0] {HIdle, HRead, HHold} harv_state_e;

    // First set bit of req at or above ptr, wrapping; ptr when req is empty.
    function automatic logic [PE_W-1:0] rr_pick(input logic [PE_COUNT-1:0] req,
                                                input logic [PE_W-1:0]     ptr);
        logic [PE_W-1:0] pick;
        logic [PE_W-1:0] idx;
        int unsigned     s;
        pick = ptr;
        for (int i = int'(PE_COUNT) - 1; i >= 0; i--) begin
            s = 32'(ptr) + 32'(i);
            if (s >= PE_COUNT) begin
                s = s - PE_COUNT;
            end
            idx = PE_W'(s);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [PE_W-1:0] wrap_inc(input logic [PE_W-1:0] p);
        return (p == PE_W'(PE_COUNT - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PE_COUNT-1:0] to_onehot(input logic [PE_W-1:0] k);
        logic [PE_COUNT-1:0] m;
        m    = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    plant_state_e        r_pstate, w_pstate_d;
    harv_state_e         r_hstate, w_hstate_d;
    logic                r_run;
    logic [PE_COUNT-1:0] r_busy;
    logic [PE_W-1:0]     r_plant_ptr;
    logic [PE_W-1:0]     r_harv_ptr;
    logic [PE_W-1:0]     r_cur;
    logic [LEN_W-1:0]    r_remaining;
    logic [LEN_W-1:0]    r_pe_length;
    logic [PE_W-1:0]     r_sel;
    logic                r_res_valid;
    logic [31:0]         r_res_data;
    logic [PE_W-1:0]     r_res_pe;

    logic [PE_COUNT-1:0] w_free;
    logic                w_any_free;
    logic [PE_W-1:0]     w_grant;
    logic [PE_COUNT-1:0] w_cand;
    logic [PE_W-1:0]     w_harv_pick;
    logic                w_job_ready;
    logic                w_plant;
    logic                w_beat;
    logic                w_streaming;
    logic [PE_COUNT-1:0] w_pe_read;
    logic                w_harv_start;
    logic                w_res_fire;
    logic [PE_COUNT-1:0] w_set_mask;
    logic [PE_COUNT-1:0] w_clr_mask;
    logic [31:0]         w_sel_data;

    assign w_free      = ~r_busy;
    assign w_any_free  = |w_free;
    assign w_grant     = rr_pick(w_free, r_plant_ptr);
    assign w_cand      = r_busy & ~i_pe_out_empty;
    assign w_harv_pick = rr_pick(w_cand, r_harv_ptr);
    assign w_streaming = (r_pstate == PStream);

    // Planter next state
    always_comb begin
        w_pstate_d  = r_pstate;
        w_job_ready = 1'b0;
        w_plant     = 1'b0;
        w_beat      = 1'b0;
        case (r_pstate)
            PIdle: begin
                // r_run keeps job_ready low while reset is asserted
                w_job_ready = r_run & w_any_free;
                if (i_job_valid && w_job_ready && (i_job_length != '0)) begin
                    w_plant    = 1'b1;
                    w_pstate_d = PStream;
                end
            end
            PStream: begin
                if (i_elem_valid) begin
                    w_beat = 1'b1;
                    if (r_remaining == LEN_W'(1)) begin
                        w_pstate_d = PIdle;
                    end
                end
            end
            default: w_pstate_d = PIdle;
        endcase
    end

    // Harvester next state
    always_comb begin
        w_hstate_d   = r_hstate;
        w_pe_read    = '0;
        w_harv_start = 1'b0;
        w_res_fire   = 1'b0;
        case (r_hstate)
            HIdle: begin
                if (|w_cand) begin
                    w_pe_read    = to_onehot(w_harv_pick);
                    w_harv_start = 1'b1;
                    w_hstate_d   = HRead;
                end
            end
            HRead: w_hstate_d = HHold;
            HHold: begin
                if (r_res_valid && i_res_ready) begin
                    w_res_fire = 1'b1;
                    w_hstate_d = HIdle;
                end
            end
            default: w_hstate_d = HIdle;
        endcase
    end

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < int'(PE_COUNT); k++) begin
            if (r_sel == PE_W'(k)) begin
                w_sel_data = i_pe_out[k*32 +: 32];
            end
        end
    end

    // Grant sees pre-edge busy, so set and clear never target the same PE.
    assign w_set_mask = w_plant ? to_onehot(w_grant) : '0;
    assign w_clr_mask = w_res_fire ? to_onehot(r_sel) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pstate <= PIdle;
            r_hstate <= HIdle;
        end else begin
            r_pstate <= w_pstate_d;
            r_hstate <= w_hstate_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run       <= 1'b0;
            r_busy      <= '0;
            r_plant_ptr <= '0;
            r_harv_ptr  <= '0;
            r_cur       <= '0;
            r_remaining <= '0;
            r_pe_length <= '0;
            r_sel       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_pe    <= '0;
        end else begin
            r_run  <= 1'b1;
            r_busy <= (r_busy | w_set_mask) & ~w_clr_mask;
            if (w_plant) begin
                r_cur       <= w_grant;
                r_remaining <= i_job_length;
                r_pe_length <= i_job_length;
                r_plant_ptr <= wrap_inc(w_grant);
            end else if (w_beat) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
            if (w_harv_start) begin
                r_sel <= w_harv_pick;
            end
            if (r_hstate == HRead) begin
                r_res_data  <= w_sel_data;
                r_res_pe    <= r_sel;
                r_res_valid <= 1'b1;
            end
            if (w_res_fire) begin
                r_res_valid <= 1'b0;
                r_harv_ptr  <= wrap_inc(r_sel);
            end
        end
    end

    assign o_job_ready  = w_job_ready;
    assign o_elem_ready = w_streaming;
    assign o_pe_active  = (w_streaming && i_elem_valid) ? to_onehot(r_cur) : '0;
    assign o_pe_left    = w_streaming ? i_elem_left : '0;
    assign o_pe_right   = w_streaming ? i_elem_right : '0;
    assign o_pe_length  = r_pe_length;
    assign o_pe_read    = w_pe_read;
    assign o_res_valid  = r_res_valid;
    assign o_res_data   = r_res_data;
    assign o_res_pe     = r_res_pe;
    assign o_busy_mask  = r_busy;

endmodule

// File: tb/tb_pe_job_scheduler.sv
// Self-checking bench for pe_job_scheduler: behavioural PE array plus a result scoreboard.
module tb_pe_job_scheduler;

    localparam int PE_COUNT = 8;
    localparam int LEN_W    = 16;
    localparam int PE_W     = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   job_valid;
    logic                   job_ready;
    logic [LEN_W-1:0]       job_length;
    logic                   elem_valid;
    logic                   elem_ready;
    logic [31:0]            elem_left;
    logic [31:0]            elem_right;
    logic [PE_COUNT-1:0]    pe_active;
    logic [LEN_W-1:0]       pe_length;
    logic [31:0]            pe_left;
    logic [31:0]            pe_right;
    logic [PE_COUNT-1:0]    pe_read;
    logic [PE_COUNT-1:0]    pe_out_empty;
    logic [PE_COUNT*32-1:0] pe_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [31:0]            res_data;
    logic [PE_W-1:0]        res_pe;
    logic [PE_COUNT-1:0]    busy_mask;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          pe;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    // PE model: accumulates on pe_active, presents the sum one cycle after pe_read
    logic [31:0] acc [PE_COUNT];
    logic [31:0] out_buf [PE_COUNT];
    int          read_cnt [PE_COUNT];
    int          ready_cnt [PE_COUNT];

    always #5 clk = ~clk;

    pe_job_scheduler #(
        .PE_COUNT (PE_COUNT),
        .LEN_W    (LEN_W),
        .PE_W     (PE_W)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_job_valid    (job_valid),
        .o_job_ready    (job_ready),
        .i_job_length   (job_length),
        .i_elem_valid   (elem_valid),
        .o_elem_ready   (elem_ready),
        .i_elem_left    (elem_left),
        .i_elem_right   (elem_right),
        .o_pe_active    (pe_active),
        .o_pe_length    (pe_length),
        .o_pe_left      (pe_left),
        .o_pe_right     (pe_right),
        .o_pe_read      (pe_read),
        .i_pe_out_empty (pe_out_empty),
        .i_pe_out       (pe_out),
        .o_res_valid    (res_valid),
        .i_res_ready    (res_ready),
        .o_res_data     (res_data),
        .o_res_pe       (res_pe),
        .o_busy_mask    (busy_mask)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PE_COUNT; k++) acc[k] <= '0;
        end else begin
            for (int k = 0; k < PE_COUNT; k++) begin
                if (pe_read[k]) begin
                    out_buf[k]  <= acc[k];
                    acc[k]      <= '0;
                    read_cnt[k] <= read_cnt[k] + 1;
                end else if (pe_active[k]) begin
                    acc[k] <= acc[k] + pe_left * pe_right;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < PE_COUNT; k++) begin
            pe_out[k*32 +: 32] = out_buf[k];
            pe_out_empty[k]    = (ready_cnt[k] == read_cnt[k]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic finish_pe(input int k);
        ready_cnt[k] = ready_cnt[k] + 1;
    endtask

    task automatic sb_push(input int pe, input logic [31:0] d);
        sb_t e;
        e.pe   = pe;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic sb_take(input int pe, output logic [31:0] d, output logic found);
        found = 1'b0;
        d     = '0;
        for (int i = 0; i < sb.size(); i++) begin
            if (!found && sb[i].pe == pe) begin
                d     = sb[i].data;
                found = 1'b1;
                sb.delete(i);
            end
        end
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0; job_valid = 1'b0; elem_valid = 1'b0; res_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // Offers one job, streams len random beats; returns first-beat pe_active and dot product.
    task automatic plant(input int len, output logic [7:0] act, output logic [31:0] sum,
                         output logic ok);
        int          budget;
        logic [31:0] l, r;
        ok = 1'b1; act = '0; sum = '0; budget = 50;
        cyc();
        job_valid = 1'b1; job_length = 16'(len);
        #1;
        while (!job_ready && budget > 0) begin cyc(); #1; budget--; end
        if (!job_ready) ok = 1'b0;
        cyc();
        job_valid = 1'b0;
        for (int b = 0; b < len; b++) begin
            if (b > 0) cyc();
            l = $urandom; r = $urandom;
            elem_valid = 1'b1; elem_left = l; elem_right = r;
            #1;
            if (b == 0) act = pe_active;
            else if (pe_active !== act) ok = 1'b0;
            if (pe_left !== l || pe_right !== r || elem_ready !== 1'b1) ok = 1'b0;
            sum = sum + l * r;
        end
        if (len > 0) begin cyc(); elem_valid = 1'b0; end
    endtask

    task automatic get_result(output int pe, output logic [31:0] data, output logic ok);
        int budget;
        budget = 40;
        #1;
        while (!res_valid && budget > 0) begin cyc(); #1; budget--; end
        ok   = res_valid;
        pe   = int'(res_pe);
        data = res_data;
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; job_valid = 1'b1; job_length = 16'd5; elem_valid = 1'b1;
        elem_left = 32'hdeadbeef; elem_right = 32'h12345678; res_ready = 1'b1;
        #2;
        n_checks++;
        if (job_ready !== 1'b0 || elem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got job=%b elem=%b want 0 0", job_ready, elem_ready);
        end
        n_checks++;
        if (pe_active !== '0 || pe_read !== '0 || busy_mask !== '0) begin
            n_fail++;
            $display("FAIL reset_masks: got act=%h read=%h busy=%h want 0", pe_active, pe_read,
                     busy_mask);
        end
        cyc(); cyc(); #1;
        n_checks++;
        if ({job_ready, elem_ready, pe_active, pe_length, pe_left, pe_right, pe_read, res_valid,
             res_data, res_pe, busy_mask} !== '0) begin
            n_fail++;
            $display("FAIL reset_all_outputs: got nonzero want all 0 (res_valid=%b pe_left=%h)",
                     res_valid, pe_left);
        end
        job_valid = 1'b0; elem_valid = 1'b0; res_ready = 1'b0;
        elem_left = '0; elem_right = '0;
        cyc();
        rst_n = 1'b1;
        cyc(); #1;
        n_checks++;
        if (job_ready !== 1'b1 || elem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_ready: got job=%b elem=%b want 1 0", job_ready, elem_ready);
        end
    endtask

    task automatic test_single();
        logic [7:0]  act;
        logic [31:0] sum, exp_d;
        logic        ok, found;
        plant(4, act, sum, ok);
        sb_push(0, sum);
        #1;
        n_checks++;
        if (!ok || act !== 8'h01) begin
            n_fail++;
            $display("FAIL single_active: got act=%h ok=%b want 01 1", act, ok);
        end
        n_checks++;
        if (pe_length !== 16'd4 || busy_mask !== 8'h01 || elem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_state: got len=%0d busy=%h erdy=%b want 4 01 0", pe_length,
                     busy_mask, elem_ready);
        end
        cyc(); finish_pe(0); #1;
        n_checks++;
        if (pe_read !== 8'h01) begin
            n_fail++;
            $display("FAIL single_read: got %h want 01", pe_read);
        end
        cyc(); #1;
        n_checks++;
        if (res_valid !== 1'b0 || pe_read !== 8'h00) begin
            n_fail++;
            $display("FAIL single_latency1: got valid=%b read=%h want 0 00", res_valid, pe_read);
        end
        cyc(); #1;
        sb_take(0, exp_d, found);
        n_checks++;
        if (res_valid !== 1'b1 || res_pe !== 3'd0 || !found || res_data !== exp_d) begin
            n_fail++;
            $display("FAIL single_result: got v=%b pe=%0d d=%h want 1 0 %h", res_valid, res_pe,
                     res_data, exp_d);
        end
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        #1;
        n_checks++;
        if (busy_mask !== 8'h00 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got busy=%h valid=%b want 00 0", busy_mask, res_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]  act;
        logic [31:0] sum, d, exp_d, l, r;
        logic        ok, found;
        int          pe;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            plant(2, act, sum, ok);
            sb_push(i, sum);
            n_checks++;
            if (!ok || act !== (8'h01 << i)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %h ok=%b want %h", i, act, ok, 8'h01 << i);
            end
        end
        cyc();
        job_valid = 1'b1; job_length = 16'd2;
        #1;
        n_checks++;
        if (job_ready !== 1'b0 || busy_mask !== 8'hff) begin
            n_fail++;
            $display("FAIL rr_full: got ready=%b busy=%h want 0 ff", job_ready, busy_mask);
        end
        finish_pe(3);
        #1;
        n_checks++;
        if (pe_read !== 8'h08) begin
            n_fail++;
            $display("FAIL rr_read3: got %h want 08", pe_read);
        end
        get_result(pe, d, ok);
        sb_take(3, exp_d, found);
        n_checks++;
        if (!ok || pe != 3 || !found || d !== exp_d) begin
            n_fail++;
            $display("FAIL rr_harvest3: got pe=%0d d=%h want 3 %h", pe, d, exp_d);
        end
        #1;
        n_checks++;
        if (job_ready !== 1'b1 || busy_mask !== 8'hf7) begin
            n_fail++;
            $display("FAIL rr_freed: got ready=%b busy=%h want 1 f7", job_ready, busy_mask);
        end
        sum = '0;
        cyc();
        job_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (b > 0) cyc();
            l = $urandom; r = $urandom;
            elem_valid = 1'b1; elem_left = l; elem_right = r;
            sum = sum + l * r;
            #1;
            n_checks++;
            if (pe_active !== 8'h08) begin
                n_fail++;
                $display("FAIL rr_ninth_beat%0d: got %h want 08", b, pe_active);
            end
        end
        cyc();
        elem_valid = 1'b0;
        sb_push(3, sum);
        for (int k = 0; k < 8; k++) finish_pe(k);
        for (int i = 0; i < 8; i++) begin
            get_result(pe, d, ok);
            sb_take((4 + i) % 8, exp_d, found);
            n_checks++;
            if (!ok || pe != (4 + i) % 8 || !found || d !== exp_d) begin
                n_fail++;
                $display("FAIL rr_drain%0d: got pe=%0d d=%h want %0d %h", i, pe, d,
                         (4 + i) % 8, exp_d);
            end
        end
    endtask

    task automatic test_stalls();
        int          pat [5];
        logic [31:0] sum, exp_d, l, r;
        logic        found;
        int          budget;
        pat = '{1, 0, 0, 1, 1};
        sum = '0;
        cyc();
        job_valid = 1'b1; job_length = 16'd3;
        #1;
        n_checks++;
        if (job_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_job_ready: got %b want 1", job_ready);
        end
        cyc();
        job_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            l = $urandom; r = $urandom;
            elem_valid = (pat[i] != 0); elem_left = l; elem_right = r;
            if (pat[i] != 0) sum = sum + l * r;
            #1;
            n_checks++;
            if (pe_active !== ((pat[i] != 0) ? 8'h10 : 8'h00) || elem_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got act=%h erdy=%b want %h 1", i, pe_active,
                         elem_ready, (pat[i] != 0) ? 8'h10 : 8'h00);
            end
            cyc();
        end
        elem_valid = 1'b0;
        #1;
        n_checks++;
        if (elem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done: got elem_ready=%b want 0", elem_ready);
        end
        sb_push(4, sum);
        finish_pe(4);
        budget = 20;
        while (!res_valid && budget > 0) begin cyc(); #1; budget--; end
        sb_take(4, exp_d, found);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_pe !== 3'd4 || !found || res_data !== exp_d) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b pe=%0d d=%h want 1 4 %h", i, res_valid,
                         res_pe, res_data, exp_d);
            end
            cyc(); #1;
        end
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        #1;
        n_checks++;
        if (busy_mask !== 8'h00 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got busy=%h v=%b want 00 0", busy_mask, res_valid);
        end
    endtask

    task automatic test_fairness();
        int          grants [6];
        int          drain [6];
        logic [7:0]  act;
        logic [31:0] sum, d, exp_d;
        logic        ok, found;
        int          pe;
        grants = '{3, 4, 5, 6, 7, 2};
        drain  = '{3, 4, 6, 7, 0, 1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            plant(1, act, sum, ok);
            sb_push(i, sum);
            n_checks++;
            if (!ok || act !== (8'h01 << i)) begin
                n_fail++;
                $display("FAIL fair_setup%0d: got %h want %h", i, act, 8'h01 << i);
            end
        end
        finish_pe(2);
        get_result(pe, d, ok);
        sb_take(2, exp_d, found);
        n_checks++;
        if (!ok || pe != 2 || !found || d !== exp_d) begin
            n_fail++;
            $display("FAIL fair_first2: got pe=%0d d=%h want 2 %h", pe, d, exp_d);
        end
        for (int i = 0; i < 6; i++) begin
            plant(1, act, sum, ok);
            sb_push(grants[i], sum);
            n_checks++;
            if (!ok || act !== (8'h01 << grants[i])) begin
                n_fail++;
                $display("FAIL fair_grant%0d: got %h want %h", i, act, 8'h01 << grants[i]);
            end
        end
        finish_pe(2);
        finish_pe(5);
        get_result(pe, d, ok);
        sb_take(5, exp_d, found);
        n_checks++;
        if (!ok || pe != 5 || !found || d !== exp_d) begin
            n_fail++;
            $display("FAIL fair_pe5_first: got pe=%0d d=%h want 5 %h", pe, d, exp_d);
        end
        get_result(pe, d, ok);
        sb_take(2, exp_d, found);
        n_checks++;
        if (!ok || pe != 2 || !found || d !== exp_d) begin
            n_fail++;
            $display("FAIL fair_pe2_second: got pe=%0d d=%h want 2 %h", pe, d, exp_d);
        end
        for (int i = 0; i < 6; i++) finish_pe(drain[i]);
        for (int i = 0; i < 6; i++) begin
            get_result(pe, d, ok);
            sb_take(drain[i], exp_d, found);
            n_checks++;
            if (!ok || pe != drain[i] || !found || d !== exp_d) begin
                n_fail++;
                $display("FAIL fair_drain%0d: got pe=%0d d=%h want %0d %h", i, pe, d, drain[i],
                         exp_d);
            end
        end
    endtask

    task automatic test_edge();
        logic [7:0]  act;
        logic [31:0] sum, d, exp_d;
        logic        ok, found, seen;
        int          pe;
        cyc();
        job_valid = 1'b1; job_length = 16'd0;
        #1;
        n_checks++;
        if (job_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len_ready: got %b want 1", job_ready);
        end
        cyc();
        job_valid = 1'b0;
        #1;
        n_checks++;
        if (busy_mask !== 8'h00 || elem_ready !== 1'b0 || pe_length !== 16'd1) begin
            n_fail++;
            $display("FAIL zero_len_state: got busy=%h erdy=%b len=%0d want 00 0 1", busy_mask,
                     elem_ready, pe_length);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            if (res_valid !== 1'b0 || pe_read !== 8'h00) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL zero_len_no_result: got activity=1 want 0");
        end
        plant(2, act, sum, ok);
        sb_push(3, sum);
        n_checks++;
        if (!ok || act !== 8'h08) begin
            n_fail++;
            $display("FAIL zero_len_ptr: got %h want 08", act);
        end
        finish_pe(3);
        get_result(pe, d, ok);
        sb_take(3, exp_d, found);
        n_checks++;
        if (!ok || pe != 3 || !found || d !== exp_d) begin
            n_fail++;
            $display("FAIL edge_harvest3: got pe=%0d d=%h want 3 %h", pe, d, exp_d);
        end
        cyc();
        job_valid = 1'b1; job_length = 16'd5;
        cyc();
        job_valid = 1'b0; elem_valid = 1'b1; elem_left = 32'h11; elem_right = 32'h22;
        #1;
        n_checks++;
        if (pe_active !== 8'h10) begin
            n_fail++;
            $display("FAIL midjob_active: got %h want 10", pe_active);
        end
        cyc();
        elem_left = 32'h33; elem_right = 32'h44;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({job_ready, elem_ready, pe_active, pe_length, pe_left, pe_right, pe_read, res_valid,
             busy_mask} !== '0) begin
            n_fail++;
            $display("FAIL midjob_async_reset: got act=%h busy=%h erdy=%b want all 0",
                     pe_active, busy_mask, elem_ready);
        end
        elem_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        plant(1, act, sum, ok);
        sb_push(0, sum);
        n_checks++;
        if (!ok || act !== 8'h01) begin
            n_fail++;
            $display("FAIL post_abort_grant: got %h want 01", act);
        end
        finish_pe(0);
        get_result(pe, d, ok);
        sb_take(0, exp_d, found);
        n_checks++;
        if (!ok || pe != 0 || !found || d !== exp_d) begin
            n_fail++;
            $display("FAIL post_abort_result: got pe=%0d d=%h want 0 %h", pe, d, exp_d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stalls();
        test_fairness();
        test_edge();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
